bcd_add_seq: RTL

- Multi-digit BCD add controller for the calculator datapath.
- Sequences a single-digit mod-10 BCD adder (no carry in or out) across NDIG packed BCD digits, least significant digit (LSD) first.
- Adds the missing carry chain: carry detection, plus a second digit-add stage that folds in the carry.
- Serial, one digit per clock. Start/busy/done handshake toward the calculator front-end FSM.

---
 rtl/bcd_add_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/bcd_add_seq.sv
// bcd_add_seq - serial multi-digit packed-BCD adder.
// Walks NDIG digits LSD first, one digit per clock. Each digit goes through
// a mod-10 digit add followed by a second stage that folds in the carry.
// The carry chain lives in a single carry register.
// Optional feature macro: BCD_SUB_EN adds an op input (1 = A-B by ten's
// complement) and a borrow output. Without the macro the block is add-only.
module bcd_add_seq #(
   parameter int NDIG = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [4*NDIG-1:0] a,
   input  logic [4*NDIG-1:0] b,
`ifdef BCD_SUB_EN
   input  logic              op,
`endif
   output logic              busy,
   output logic              done,
   output logic [4*NDIG-1:0] sum,
   output logic              cout,
   output logic              err
`ifdef BCD_SUB_EN
   ,
   output logic              borrow
`endif
);

   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // A digit is legal BCD only when it is 0..9.
   function automatic logic dig_ok(input logic [3:0] d);
      return (d <= 4'd9);
   endfunction

   // Two-stage digit add: {carry_out, sum_digit}.
   // Stage 1 is the carry-less mod-10 add of da and db (raw 10..18 is
   // corrected by +6 in the low nibble). Stage 2 folds the incoming carry
   // into that digit, wrapping 10 back to 0. The carry out is taken from the
   // full da+db+cin total, since neither stage alone sees it.
   function automatic logic [4:0] dig_step(input logic [3:0] da,
                                           input logic [3:0] db,
                                           input logic       cin);
      logic [4:0] raw_v;
      logic [3:0] s0_v;
      logic [3:0] t_v;
      logic [3:0] s_v;
      logic       c_v;
      raw_v = {1'b0, da} + {1'b0, db};
      if (raw_v >= 5'd10) begin
         s0_v = raw_v[3:0] + 4'd6;
      end else begin
         s0_v = raw_v[3:0];
      end
      t_v = s0_v + {3'd0, cin};
      if (t_v >= 4'd10) begin
         s_v = t_v - 4'd10;
      end else begin
         s_v = t_v;
      end
      c_v = ((raw_v + {4'd0, cin}) > 5'd9);
      return {c_v, s_v};
   endfunction

   state_t              state_r;
   logic [IW-1:0]       idx_r;
   logic                carry_r;
   logic [4*NDIG-1:0]   a_sh_r;
   logic [4*NDIG-1:0]   b_sh_r;
   logic [4*NDIG-1:0]   sum_r;
   logic                busy_r;
   logic                done_r;
   logic                cout_r;
   logic                err_r;
`ifdef BCD_SUB_EN
   logic                op_r;
   logic                borrow_r;
`endif

   logic [3:0]          da_s;
   logic [3:0]          db_raw_s;
   logic [3:0]          db_eff_s;
   logic                valid_s;
   logic [4:0]          step_s;
   logic [3:0]          s_s;
   logic                c_nx_s;

   // Current digit datapath: select digit idx, apply subtract complement, add.
   always_comb begin
      da_s     = a_sh_r[idx_r*4 +: 4];
      db_raw_s = b_sh_r[idx_r*4 +: 4];
      db_eff_s = db_raw_s;
      s_s      = 4'd0;
      c_nx_s   = 1'b0;
      valid_s  = dig_ok(da_s) && dig_ok(db_raw_s);
`ifdef BCD_SUB_EN
      if (op_r) begin
         db_eff_s = 4'd9 - db_raw_s;
      end else begin
         db_eff_s = db_raw_s;
      end
`endif
      step_s = dig_step(da_s, db_eff_s, carry_r);
      if (valid_s) begin
         s_s    = step_s[3:0];
         c_nx_s = step_s[4];
      end else begin
         s_s    = 4'd0;
         c_nx_s = 1'b0;
      end
   end

   // Control FSM plus all registered outputs and the carry/index state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         idx_r    <= '0;
         carry_r  <= 1'b0;
         a_sh_r   <= '0;
         b_sh_r   <= '0;
         sum_r    <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         cout_r   <= 1'b0;
         err_r    <= 1'b0;
`ifdef BCD_SUB_EN
         op_r     <= 1'b0;
         borrow_r <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  a_sh_r  <= a;
                  b_sh_r  <= b;
                  sum_r   <= '0;
                  err_r   <= 1'b0;
                  idx_r   <= '0;
                  busy_r  <= 1'b1;
                  state_r <= ST_RUN;
`ifdef BCD_SUB_EN
                  op_r    <= op;
                  // Ten's complement: nine's complement of B plus one.
                  carry_r <= op;
`else
                  carry_r <= 1'b0;
`endif
               end
            end
            ST_RUN: begin
               sum_r[idx_r*4 +: 4] <= s_s;
               carry_r             <= c_nx_s;
               if (!valid_s) begin
                  err_r <= 1'b1;
               end
               if (idx_r == LAST_IDX) begin
                  cout_r   <= c_nx_s;
`ifdef BCD_SUB_EN
                  borrow_r <= ~c_nx_s;
`endif
                  done_r   <= 1'b1;
                  state_r  <= ST_DONE;
               end else begin
                  idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
               end
            end
            ST_DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_r;
   assign done   = done_r;
   assign sum    = sum_r;
   assign cout   = cout_r;
   assign err    = err_r;
`ifdef BCD_SUB_EN
   assign borrow = borrow_r;
`endif

endmodule
